// File: rtl/pwm_meas_pkg.sv
// pwm_meas_pkg: shared state encoding and default sizing for the PWM duty meter
package pwm_meas_pkg;

    localparam int CNT_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 1000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        HIGH = ST_HIGH,
        LOW  = ST_LOW
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer, asynchronously reset to 0
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, sync_q;

    // Shift the raw input through two flops on every clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures PWM high time and period in ce sample ticks, flags stuck lines
module pwm_duty_meter
    import pwm_meas_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce_i,
    input  logic             pwm_in_i,
    output logic [CNT_W-1:0] high_cnt_o,
    output logic [CNT_W:0]   period_cnt_o,
    output logic             meas_valid_o,
    output logic             stuck_high_o,
    output logic             stuck_low_o
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    state_t           state_q;
    logic             s, s_prev_q, rise, fall, any_edge, hit;
    logic [CNT_W-1:0] run_acc_q, run_acc_d, hi_len_q, high_cnt_q;
    logic [CNT_W:0]   period_cnt_q;
    logic             meas_valid_q, stuck_high_q, stuck_low_q;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pwm_in_i),
        .q_o (s)
    );

    assign rise      = s & ~s_prev_q;
    assign fall      = ~s & s_prev_q;
    assign any_edge  = rise | fall;
    // An edge on the sample that would saturate the counter wins over the timeout
    assign hit       = ~any_edge & (run_acc_q == TMO - 1'b1);
    assign run_acc_d = any_edge ? CNT_W'(1) : (run_acc_q == TMO) ? run_acc_q : run_acc_q + 1'b1;

    // Sample-rate datapath: previous level, saturating run length, latched high time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_prev_q  <= 1'b0;
            run_acc_q <= '0;
            hi_len_q  <= '0;
        end else if (ce_i) begin
            s_prev_q  <= s;
            run_acc_q <= run_acc_d;
            if (fall) hi_len_q <= run_acc_q;
        end
    end

    // Measurement FSM with registered publish and stuck-line outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            meas_valid_q <= 1'b0;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;
            if (ce_i) begin
                if (rise) begin
                    state_q      <= HIGH;
                    stuck_high_q <= 1'b0;
                    stuck_low_q  <= 1'b0;
                    if (state_q == LOW) begin
                        high_cnt_q   <= hi_len_q;
                        period_cnt_q <= {1'b0, hi_len_q} + {1'b0, run_acc_q};
                        meas_valid_q <= 1'b1;
                    end
                end else if (fall) begin
                    state_q      <= LOW;
                    stuck_high_q <= 1'b0;
                    stuck_low_q  <= 1'b0;
                end else if (hit) begin
                    state_q      <= IDLE;
                    stuck_high_q <= s;
                    stuck_low_q  <= ~s;
                end
            end
        end
    end

    assign high_cnt_o   = high_cnt_q;
    assign period_cnt_o = period_cnt_q;
    assign meas_valid_o = meas_valid_q;
    assign stuck_high_o = stuck_high_q;
    assign stuck_low_o  = stuck_low_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// tb_pwm_duty_meter: random and directed PWM stimulus checked against run-length expectations
module tb_pwm_duty_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1000;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             ce_i     = 1'b1;
    logic             pwm_in_i = 1'b0;
    logic [CNT_W-1:0] high_cnt_o;
    logic [CNT_W:0]   period_cnt_o;
    logic             meas_valid_o, stuck_high_o, stuck_low_o;

    int n_cmp = 0;
    int n_err = 0;
    int exp_h[$];
    int exp_p[$];
    int pubs = 0;
    bit any_stuck = 0;
    bit both_stuck = 0;
    int ce_mode = 0;
    int ce_div = 16;
    int gap = 0;
    bit have_prev = 0;
    int prev_h = 0;
    int prev_l = 0;

    pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .ce_i         (ce_i),
        .pwm_in_i     (pwm_in_i),
        .high_cnt_o   (high_cnt_o),
        .period_cnt_o (period_cnt_o),
        .meas_valid_o (meas_valid_o),
        .stuck_high_o (stuck_high_o),
        .stuck_low_o  (stuck_low_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Every publish must match the oldest outstanding expected period
    always @(negedge clk) begin
        if (stuck_high_o | stuck_low_o) any_stuck = 1;
        if (stuck_high_o & stuck_low_o) both_stuck = 1;
        if (meas_valid_o) begin
            pubs++;
            if (exp_h.size() == 0) check("spurious_valid", 1, 0);
            else begin
                check("high_cnt", high_cnt_o, exp_h.pop_front());
                check("period_cnt", period_cnt_o, exp_p.pop_front());
            end
        end
    end

    // Advance one clk; ce gaps are 1 or at least 3 clk so the synchronizer lag is constant in samples
    task automatic tick(output bit was_ce);
        was_ce = ce_i;
        @(posedge clk);
        #1;
        if (ce_mode == 0) ce_i = 1'b1;
        else if (gap == 0) begin
            ce_i = 1'b1;
            gap  = (ce_mode == 1) ? ce_div - 1 : int'($urandom_range(2, 5));
        end else begin
            ce_i = 1'b0;
            gap--;
        end
    endtask

    task automatic hold(input bit lvl, input int n);
        int k = 0;
        bit c;
        pwm_in_i = lvl;
        while (k < n) begin
            tick(c);
            if (c) k++;
        end
    endtask

    task automatic rise_push();
        if (have_prev) begin
            exp_h.push_back(prev_h);
            exp_p.push_back(prev_h + prev_l);
        end
        have_prev = 0;
    endtask

    task automatic pulse(input int h, input int l);
        rise_push();
        hold(1'b1, h);
        hold(1'b0, l);
        prev_h    = h;
        prev_l    = l;
        have_prev = 1;
    endtask

    task automatic drain(input string tag, input int n_exp);
        hold(1'b0, 20);
        if (have_prev) prev_l += 20;
        check({tag, "_pending"}, exp_h.size(), 0);
        check({tag, "_pubs"}, pubs, n_exp);
        pubs = 0;
    endtask

    task automatic do_reset(input int mode);
        bit c;
        rst       = 1'b1;
        pwm_in_i  = 1'b0;
        ce_mode   = mode;
        gap       = 0;
        have_prev = 0;
        exp_h.delete();
        exp_p.delete();
        repeat (3) tick(c);
        rst        = 1'b0;
        pubs       = 0;
        any_stuck  = 0;
        both_stuck = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_high_cnt"}, high_cnt_o, 0);
        check({tag, "_period_cnt"}, period_cnt_o, 0);
        check({tag, "_meas_valid"}, meas_valid_o, 0);
        check({tag, "_stuck_high"}, stuck_high_o, 0);
        check({tag, "_stuck_low"}, stuck_low_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int duties[6] = '{1, 2, 77, 150, 198, 199};
        do_reset(0);
        check_zero("reset");

        hold(1'b0, 5);
        repeat (3) pulse(50, 151);
        pulse(5, 5);
        drain("basic", 3);

        rise_push();
        hold(1'b1, 1001);
        check("stuck_high_early", stuck_high_o, 0);
        hold(1'b1, 1);
        check("stuck_high_set", stuck_high_o, 1);
        check("stuck_low_while_high", stuck_low_o, 0);
        hold(1'b0, 2);
        check("stuck_high_before_fall", stuck_high_o, 1);
        hold(1'b0, 1);
        check("stuck_high_cleared", stuck_high_o, 0);
        drain("stuck_hi", 1);

        rst = 1'b1;
        #1;
        check_zero("mid_reset");
        do_reset(0);
        repeat (3) pulse(10, 10);
        pulse(5, 5);
        drain("after_reset", 3);

        do_reset(0);
        hold(1'b0, 999);
        check("stuck_low_early", stuck_low_o, 0);
        hold(1'b0, 1);
        check("stuck_low_set", stuck_low_o, 1);
        check("stuck_high_while_low", stuck_high_o, 0);
        rise_push();
        hold(1'b1, 2);
        check("stuck_low_before_rise", stuck_low_o, 1);
        hold(1'b1, 1);
        check("stuck_low_cleared", stuck_low_o, 0);
        hold(1'b1, 17);
        hold(1'b0, 30);
        prev_h = 20;
        prev_l = 30;
        have_prev = 1;
        check("stuck_lo_no_pub", pubs, 0);
        pulse(5, 5);
        drain("stuck_lo", 1);

        any_stuck = 0;
        pulse(999, 1);
        pulse(5, 5);
        drain("edge_at_timeout", 2);
        check("edge_at_timeout_no_stuck", any_stuck, 0);

        do_reset(1);
        hold(1'b0, 3);
        foreach (duties[i]) pulse(duties[i], 201 - duties[i]);
        pulse(5, 5);
        drain("ramp", 6);

        do_reset(2);
        hold(1'b0, 4);
        for (int i = 0; i < 14; i++) begin
            if (i == 7) pulse(1, 1);
            else pulse(($urandom_range(0, 4) == 0) ? 1 : int'($urandom_range(1, 250)),
                       ($urandom_range(0, 4) == 0) ? 1 : int'($urandom_range(1, 250)));
        end
        pulse(3, 3);
        drain("random", 14);
        check("random_no_stuck", any_stuck, 0);
        check("never_both_stuck", both_stuck, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
